// File: rtl/general_register_pkg.sv
// Shared types for the general register file write path: register indices,
// byte-lane enable patterns and the request record handed to the lane decoder.
package general_register_pkg;

  typedef enum logic [2:0] {
    EAX = 3'd0,
    ECX = 3'd1,
    EDX = 3'd2,
    EBX = 3'd3,
    ESP = 3'd4,
    EBP = 3'd5,
    ESI = 3'd6,
    EDI = 3'd7
  } reg_index_e;

  localparam logic [3:0] BE_LO8 = 4'b0001;
  localparam logic [3:0] BE_HI8 = 4'b0010;
  localparam logic [3:0] BE_16  = 4'b0011;
  localparam logic [3:0] BE_32  = 4'b1111;

  typedef struct packed {
    logic        w;
    logic        size32;
    logic [2:0]  code;
    logic [31:0] data;
  } reg_req_t;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Expands per-byte enables into a 32-bit data mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/general_register_lane_decode.sv
// Translates an instruction-level register reference into a physical index,
// byte enables and lane-aligned data. Purely combinational.
module general_register_lane_decode
  import general_register_pkg::*;
(
  input  reg_req_t    req,
  output logic [2:0]  index,
  output logic [3:0]  byte_en,
  output logic [31:0] data
);

  logic [31:0] placed_s;

  // Select lane placement from the w bit and operand size.
  always_comb begin
    index    = req.code;
    byte_en  = BE_LO8;
    placed_s = 32'd0;
    case ({req.w, req.size32})
      2'b10: begin
        byte_en  = BE_16;
        placed_s = {16'd0, req.data[15:0]};
      end
      2'b11: begin
        byte_en  = BE_32;
        placed_s = req.data;
      end
      default: begin
        // Codes 4..7 with w=0 name the high byte (AH..BH) of registers 0..3.
        index = {1'b0, req.code[1:0]};
        if (req.code[2]) begin
          byte_en  = BE_HI8;
          placed_s = {16'd0, req.data[7:0], 8'd0};
        end else begin
          byte_en  = BE_LO8;
          placed_s = {24'd0, req.data[7:0]};
        end
      end
    endcase
  end

  assign data = placed_s & be_mask(byte_en);

endmodule

// File: rtl/general_register_write_arbiter.sv
// Round-robin arbiter with ownership lock sharing the general register file
// write port; the granted request is decoded and registered into the port.
module general_register_write_arbiter
  import general_register_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ-1:0]        req_w,
  input  logic [N_REQ-1:0]        req_size32,
  input  logic [N_REQ*3-1:0]      req_register_sequence_code,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    wr_en,
  output logic [2:0]              wr_index,
  output logic [3:0]              wr_byte_en,
  output logic [DATA_W-1:0]       wr_data,
  input  logic [2:0]              rd_index,
  output logic                    rd_hazard,
  output logic                    locked
);

  localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

  arb_state_e       state_r;
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] owner_r;

  logic [N_REQ-1:0] grant_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic             grant_any_s;
  logic             sel_lock_s;
  reg_req_t         sel_req_s;
  logic [2:0]       dec_index_s;
  logic [3:0]       dec_byte_en_s;
  logic [31:0]      dec_data_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == N_REQ - 1) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Pick the requester to grant this cycle; owner only while locked.
  always_comb begin
    int cand;
    grant_idx_s = ptr_r;
    grant_any_s = 1'b0;
    cand        = 0;
    if (state_r == ST_LOCKED) begin
      grant_idx_s = owner_r;
      grant_any_s = req_valid[owner_r];
    end else begin
      // Scan farthest-first so the requester nearest ptr is assigned last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = (int'(ptr_r) + k >= N_REQ) ? int'(ptr_r) + k - N_REQ : int'(ptr_r) + k;
        grant_idx_s = req_valid[cand] ? PTR_W'(cand) : grant_idx_s;
        grant_any_s = grant_any_s | req_valid[cand];
      end
    end
    if (reset) begin
      grant_any_s = 1'b0;
    end else begin
      grant_any_s = grant_any_s;
    end
    for (int i = 0; i < N_REQ; i++) begin
      grant_s[i] = grant_any_s && (int'(grant_idx_s) == i);
    end
  end

  assign req_ready = grant_s;

  // Gather the granted requester's fields into one request record.
  always_comb begin
    sel_req_s.w      = req_w[grant_idx_s];
    sel_req_s.size32 = req_size32[grant_idx_s];
    sel_req_s.code   = req_register_sequence_code[int'(grant_idx_s)*3 +: 3];
    sel_req_s.data   = req_data[int'(grant_idx_s)*DATA_W +: 32];
    sel_lock_s       = req_lock[grant_idx_s];
  end

  general_register_lane_decode u_lane_decode (
    .req     (sel_req_s),
    .index   (dec_index_s),
    .byte_en (dec_byte_en_s),
    .data    (dec_data_s)
  );

  // Arbiter state, round-robin pointer and registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_ARB;
      ptr_r      <= '0;
      owner_r    <= '0;
      wr_en      <= 1'b0;
      wr_index   <= 3'd0;
      wr_byte_en <= 4'd0;
      wr_data    <= '0;
    end else begin
      wr_en <= grant_any_s;
      if (grant_any_s) begin
        wr_index   <= dec_index_s;
        wr_byte_en <= dec_byte_en_s;
        wr_data    <= DATA_W'(dec_data_s);
        ptr_r      <= ptr_inc(grant_idx_s);
        owner_r    <= grant_idx_s;
        // A locked grant keeps (or takes) ownership; an unlocked one frees it.
        state_r    <= sel_lock_s ? ST_LOCKED : ST_ARB;
      end
    end
  end

  assign locked    = (state_r == ST_LOCKED);
  assign rd_hazard = wr_en && (rd_index == wr_index);

endmodule

// File: tb/tb_general_register_write_arbiter.sv
// Directed and random stimulus for the register write arbiter, checked against
// a behavioural model of the arbitration, lock and lane placement rules.
module tb_general_register_write_arbiter;

  localparam int N = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    ready;
  logic [N-1:0]    lock = '0;
  logic [N-1:0]    w = '0;
  logic [N-1:0]    s32 = '0;
  logic [N*3-1:0]  code = '0;
  logic [N*32-1:0] data = '0;
  logic            wr_en;
  logic [2:0]      wr_index;
  logic [3:0]      wr_byte_en;
  logic [31:0]     wr_data;
  logic [2:0]      rd_index = 3'd0;
  logic            rd_hazard;
  logic            locked;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit          m_locked = 1'b0;
  int          m_owner = 0;
  int          m_ptr = 0;
  bit          m_wr_en = 1'b0;
  int          m_idx = 0;
  int          m_be = 0;
  logic [31:0] m_data = 32'd0;

  always #5 clock = ~clock;

  general_register_write_arbiter #(.N_REQ(N), .DATA_W(32)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .req_valid                  (valid),
    .req_ready                  (ready),
    .req_lock                   (lock),
    .req_w                      (w),
    .req_size32                 (s32),
    .req_register_sequence_code (code),
    .req_data                   (data),
    .wr_en                      (wr_en),
    .wr_index                   (wr_index),
    .wr_byte_en                 (wr_byte_en),
    .wr_data                    (wr_data),
    .rd_index                   (rd_index),
    .rd_hazard                  (rd_hazard),
    .locked                     (locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic ww,
                         input logic s, input logic [2:0] c, input logic [31:0] d);
    valid[i]        = v;
    lock[i]         = l;
    w[i]            = ww;
    s32[i]          = s;
    code[i*3 +: 3]  = c;
    data[i*32 +: 32] = d;
  endtask

  function automatic int model_grant();
    if (reset) return -1;
    if (m_locked) return valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int c = (m_ptr + k) % N;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check grant before the edge, write port and hazard after it.
  task automatic do_cycle(input string tag);
    int g;
    int c;
    logic [31:0] d;
    logic [N-1:0] exp_ready;
    #1;
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check({tag, "_ready"}, 32'(ready), 32'(exp_ready));
    @(posedge clock);
    if (reset) begin
      m_locked = 1'b0; m_ptr = 0; m_owner = 0;
      m_wr_en = 1'b0; m_idx = 0; m_be = 0; m_data = 32'd0;
    end else if (g >= 0) begin
      c = int'(code[g*3 +: 3]);
      d = data[g*32 +: 32];
      m_wr_en = 1'b1;
      if (!w[g]) begin
        m_idx = c % 4;
        if (c >= 4) begin m_be = 2; m_data = (d % 256) * 256; end
        else begin m_be = 1; m_data = d % 256; end
      end else if (!s32[g]) begin
        m_idx = c; m_be = 3; m_data = d % 65536;
      end else begin
        m_idx = c; m_be = 15; m_data = d;
      end
      m_ptr = (g + 1) % N;
      if (m_locked) m_locked = lock[g];
      else if (lock[g]) begin m_locked = 1'b1; m_owner = g; end
    end else begin
      m_wr_en = 1'b0;
    end
    #1;
    check({tag, "_wr_en"}, 32'(wr_en), 32'(m_wr_en));
    check({tag, "_wr_index"}, 32'(wr_index), m_idx);
    check({tag, "_wr_byte_en"}, 32'(wr_byte_en), m_be);
    check({tag, "_wr_data"}, wr_data, m_data);
    check({tag, "_locked"}, 32'(locked), 32'(m_locked));
    rd_index = 3'(m_idx);
    #1;
    check({tag, "_hazard_hit"}, 32'(rd_hazard), 32'(m_wr_en));
    rd_index = 3'(m_idx ^ 1);
    #1;
    check({tag, "_hazard_miss"}, 32'(rd_hazard), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    do_cycle("rst0");
    do_cycle("rst1");
    reset = 1'b0;

    // Byte write to AH
    set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 32'h0000_005A);
    do_cycle("tp1");
    check("tp1_data_const", wr_data, 32'h0000_5A00);
    check("tp1_be_const", 32'(wr_byte_en), 32'h2);
    valid = '0;
    do_cycle("idle1");

    // Three dword writers from reset
    reset = 1'b1;
    do_cycle("rst2");
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b1, 1'b1, 3'(i + 1), $urandom);
    do_cycle("tp2_g0");
    do_cycle("tp2_g1");
    do_cycle("tp2_g2");
    check("tp2_idx_const", 32'(wr_index), 32'd3);

    // Requester 1 takes a two-write lock while 0 and 2 stay valid
    lock[1] = 1'b1;
    do_cycle("tp3_g0");
    do_cycle("tp3_lock");
    check("tp3_locked_const", 32'(locked), 32'd1);
    lock[1] = 1'b0;
    do_cycle("tp3_release");
    check("tp3_unlocked_const", 32'(locked), 32'd0);
    do_cycle("tp3_g2");

    // Reset while requester 2 owns the lock
    valid = 3'b100;
    lock  = 3'b100;
    do_cycle("tp4_lock2");
    valid = 3'b100;
    do_cycle("tp4_hold");
    valid = 3'b111;
    reset = 1'b1;
    do_cycle("tp4_rst");
    reset = 1'b0;
    lock = '0;
    #1;
    check("tp4_first_const", 32'(ready), 32'd1);
    do_cycle("tp4_first");

    // 16-bit write to SI with read hazard probing
    valid = '0;
    set_req(1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b110, 32'h1234_5678);
    do_cycle("tp6");
    check("tp6_index_const", 32'(wr_index), 32'd6);
    check("tp6_data_const", wr_data, 32'h0000_5678);
    valid = '0;
    do_cycle("idle2");

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 1'($urandom),
                1'($urandom), 3'($urandom), $urandom);
      do_cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
